// File: rtl/frame_read_arbiter.sv
// frame_read_arbiter: shares the frame BRAM read port between the VGA display
// path (absolute priority) and two background readers (A: blob scanner,
// B: calibration sampler), round-robin on idle cycles. Returned words are
// tagged with a per-client valid pulse aligned to 1+RD_LAT cycles after grant.
//
// Registered state (no multi-state FSM; the round-robin pointer is one bit):
//   last_b_q | 1 = B was granted most recently (A wins the next tie)
//   tag_q    | per-stage owner of the read in flight (none/A/B/display)
//   wait_*_q | cycles the client has been waiting while requesting
//   starve_q | sticky "waited STARVE_CYC cycles" flags
module frame_read_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int RD_LAT     = 2,
  parameter int STARVE_CYC = 1024
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              disp_en_in,
  input  logic [ADDR_W-1:0] disp_addr_in,
  input  logic              req_a_in,
  input  logic              req_b_in,
  input  logic [ADDR_W-1:0] addr_a_in,
  input  logic [ADDR_W-1:0] addr_b_in,
  output logic              gnt_a_out,
  output logic              gnt_b_out,
  output logic              rd_valid_a_out,
  output logic              rd_valid_b_out,
  output logic [DATA_W-1:0] rd_data_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  input  logic [DATA_W-1:0] bram_dout_in,
  output logic [1:0]        starve_out,
  output logic              idle_out
);

  localparam int CW = $clog2(STARVE_CYC + 1);
  localparam logic [CW-1:0] WAIT_SAT = CW'(STARVE_CYC);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_A    = 2'd1,
    TAG_B    = 2'd2,
    TAG_DISP = 2'd3
  } tag_t;

  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [RD_LAT:0][1:0]   tag_q, tag_d;
  logic                   last_b_q, last_b_d;
  logic [CW-1:0]          wait_a_q, wait_a_d;
  logic [CW-1:0]          wait_b_q, wait_b_d;
  logic [1:0]             starve_q, starve_d;
  logic                   gnt_a, gnt_b;
  tag_t                   new_tag;
  logic                   busy;

  // Arbitration: display first, then single requester, then round-robin tie.
  always_comb begin
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    addr_d   = addr_q;
    new_tag  = TAG_NONE;
    last_b_d = last_b_q;
    if (disp_en_in) begin
      addr_d  = disp_addr_in;
      new_tag = TAG_DISP;
    end else if (req_a_in && (!req_b_in || last_b_q)) begin
      gnt_a    = rst_in_n;
      addr_d   = addr_a_in;
      new_tag  = TAG_A;
      last_b_d = 1'b0;
    end else if (req_b_in) begin
      gnt_b    = rst_in_n;
      addr_d   = addr_b_in;
      new_tag  = TAG_B;
      last_b_d = 1'b1;
    end
  end

  // Tag pipeline shift; stage RD_LAT lines up with data on bram_dout_in.
  always_comb begin
    tag_d    = tag_q;
    tag_d[0] = new_tag;
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  // Wait counters saturate; flags latch once a counter reaches the limit.
  always_comb begin
    wait_a_d = '0;
    wait_b_d = '0;
    if (req_a_in && !gnt_a) begin
      wait_a_d = (wait_a_q == WAIT_SAT) ? WAIT_SAT : wait_a_q + CW'(1);
    end
    if (req_b_in && !gnt_b) begin
      wait_b_d = (wait_b_q == WAIT_SAT) ? WAIT_SAT : wait_b_q + CW'(1);
    end
    starve_d = starve_q | {(wait_b_d == WAIT_SAT), (wait_a_d == WAIT_SAT)};
  end

  // Idle only when nothing is requested and no client read is in flight.
  always_comb begin
    busy = req_a_in | req_b_in;
    for (int i = 0; i <= RD_LAT; i++) begin
      if (tag_q[i] == TAG_A || tag_q[i] == TAG_B) begin
        busy = 1'b1;
      end
    end
  end

  // State registers; reset discards every in-flight tag.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      addr_q   <= '0;
      tag_q    <= '0;
      last_b_q <= 1'b1;
      wait_a_q <= '0;
      wait_b_q <= '0;
      starve_q <= '0;
    end else begin
      addr_q   <= addr_d;
      tag_q    <= tag_d;
      last_b_q <= last_b_d;
      wait_a_q <= wait_a_d;
      wait_b_q <= wait_b_d;
      starve_q <= starve_d;
    end
  end

  assign gnt_a_out      = gnt_a;
  assign gnt_b_out      = gnt_b;
  assign rd_valid_a_out = (tag_q[RD_LAT] == TAG_A);
  assign rd_valid_b_out = (tag_q[RD_LAT] == TAG_B);
  assign rd_data_out    = bram_dout_in;
  assign bram_addr_out  = addr_q;
  assign starve_out     = starve_q;
  assign idle_out       = ~busy;

endmodule

// File: tb/tb_frame_read_arbiter.sv
// Bench for frame_read_arbiter: randomized and directed stimulus, reference
// model of the arbitration rules, and a scoreboard of expected read returns.
module tb_frame_read_arbiter;

  localparam int AW = 17;
  localparam int DW = 12;
  localparam int RL = 2;
  localparam int SC = 16;

  logic          clk_in = 1'b0;
  logic          rst_in_n;
  logic          disp_en_in;
  logic [AW-1:0] disp_addr_in;
  logic          req_a_in, req_b_in;
  logic [AW-1:0] addr_a_in, addr_b_in;
  logic          gnt_a_out, gnt_b_out;
  logic          rd_valid_a_out, rd_valid_b_out;
  logic [DW-1:0] rd_data_out;
  logic [AW-1:0] bram_addr_out;
  logic [DW-1:0] bram_dout_in;
  logic [1:0]    starve_out;
  logic          idle_out;

  frame_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL), .STARVE_CYC(SC)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n),
    .disp_en_in(disp_en_in), .disp_addr_in(disp_addr_in),
    .req_a_in(req_a_in), .req_b_in(req_b_in),
    .addr_a_in(addr_a_in), .addr_b_in(addr_b_in),
    .gnt_a_out(gnt_a_out), .gnt_b_out(gnt_b_out),
    .rd_valid_a_out(rd_valid_a_out), .rd_valid_b_out(rd_valid_b_out),
    .rd_data_out(rd_data_out), .bram_addr_out(bram_addr_out),
    .bram_dout_in(bram_dout_in), .starve_out(starve_out), .idle_out(idle_out)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] v;
    v = (a * 17'd13) ^ (a >> 7);
    return v[DW-1:0];
  endfunction

  // BRAM model with RL cycles from address to data
  logic [DW-1:0] bram_pipe [RL];
  always @(posedge clk_in) begin
    bram_pipe[0] <= mem_word(bram_addr_out);
    for (int i = 1; i < RL; i++) bram_pipe[i] <= bram_pipe[i-1];
  end
  assign bram_dout_in = bram_pipe[RL-1];

  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int            client;
    logic [DW-1:0] data;
    int            due;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state
  int            m_last;      // 1 = A granted last, 2 = B granted last
  logic [AW-1:0] m_addr;
  int            m_wait_a, m_wait_b;
  logic [1:0]    m_starve;
  int            m_last_due;
  int            m_win;
  logic          m_idle;

  initial begin
    m_last = 2; m_addr = '0; m_wait_a = 0; m_wait_b = 0; m_starve = '0; m_last_due = -1;
  end

  // Reference model: checks grants, address, flags, idle; issues expectations
  always @(negedge clk_in) begin
    if (!rst_in_n) begin
      check("rst_gnt", {30'd0, gnt_b_out, gnt_a_out}, 32'd0);
      check("rst_valid", {30'd0, rd_valid_b_out, rd_valid_a_out}, 32'd0);
      check("rst_addr", 32'(bram_addr_out), 32'd0);
      check("rst_starve", 32'(starve_out), 32'd0);
      m_last = 2; m_addr = '0; m_wait_a = 0; m_wait_b = 0; m_starve = '0;
      m_last_due = -1;
      exp_q.delete();
    end else begin
      check("bram_addr", 32'(bram_addr_out), 32'(m_addr));
      check("starve", 32'(starve_out), 32'(m_starve));
      m_idle = !req_a_in && !req_b_in && (cyc > m_last_due);
      check("idle", 32'(idle_out), 32'(m_idle));
      if (disp_en_in)                  m_win = 3;
      else if (req_a_in && req_b_in)   m_win = (m_last == 2) ? 1 : 2;
      else if (req_a_in)               m_win = 1;
      else if (req_b_in)               m_win = 2;
      else                             m_win = 0;
      check("gnt_a", 32'(gnt_a_out), 32'(m_win == 1));
      check("gnt_b", 32'(gnt_b_out), 32'(m_win == 2));
      if (m_win == 3) m_addr = disp_addr_in;
      if (m_win == 1 || m_win == 2) begin
        m_addr = (m_win == 1) ? addr_a_in : addr_b_in;
        m_last = m_win;
        m_last_due = cyc + 1 + RL;
        exp_q.push_back('{client: m_win, data: mem_word(m_addr), due: m_last_due});
      end
      m_wait_a = (req_a_in && m_win != 1) ? ((m_wait_a + 1 > SC) ? SC : m_wait_a + 1) : 0;
      m_wait_b = (req_b_in && m_win != 2) ? ((m_wait_b + 1 > SC) ? SC : m_wait_b + 1) : 0;
      if (m_wait_a >= SC) m_starve[0] = 1'b1;
      if (m_wait_b >= SC) m_starve[1] = 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a valid word
  always @(negedge clk_in) begin
    if (rst_in_n) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        check("missing_valid", 32'(exp_q[0].due), 32'(cyc));
        void'(exp_q.pop_front());
      end
      if (rd_valid_a_out || rd_valid_b_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", {30'd0, rd_valid_b_out, rd_valid_a_out}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("valid_client", {30'd0, rd_valid_b_out, rd_valid_a_out}, 32'(e.client));
          check("valid_data", 32'(rd_data_out), 32'(e.data));
          check("valid_cycle", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  logic ga, gb;
  logic [1:0] st;
  logic [AW-1:0] ab;

  task automatic tick();
    @(negedge clk_in);
    ga = gnt_a_out; gb = gnt_b_out; st = starve_out; ab = bram_addr_out;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in_n = 1'b0;
    req_a_in = 1'b0; req_b_in = 1'b0; disp_en_in = 1'b0;
    tick();
    rst_in_n = 1'b1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, 76799));
  endfunction

  initial begin
    rst_in_n = 1'b0;
    disp_en_in = 1'b0; disp_addr_in = '0;
    req_a_in = 1'b0; req_b_in = 1'b0; addr_a_in = '0; addr_b_in = '0;
    repeat (3) tick();
    rst_in_n = 1'b1;
    tick();

    // single A read
    req_a_in = 1'b1; addr_a_in = 17'h00123;
    tick();
    check("t1_gnt_a", 32'(ga), 32'd1);
    req_a_in = 1'b0;
    tick();
    check("t1_addr", 32'(ab), 32'h123);
    repeat (4) tick();

    // both requesting: strict alternation starting with A after reset
    do_reset();
    req_a_in = 1'b1; req_b_in = 1'b1; addr_a_in = rnd_addr(); addr_b_in = rnd_addr();
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_alt_a", 32'(ga), 32'((i % 2) == 0));
      check("t2_alt_b", 32'(gb), 32'((i % 2) == 1));
      if (ga) addr_a_in = rnd_addr();
      if (gb) addr_b_in = rnd_addr();
    end
    req_a_in = 1'b0; req_b_in = 1'b0;
    repeat (5) tick();

    // display priority over pending B
    req_b_in = 1'b1; addr_b_in = 17'h1ABCD; disp_en_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      disp_addr_in = AW'(1000 + i);
      tick();
      check("t3_gnt_b_blocked", 32'(gb), 32'd0);
    end
    disp_en_in = 1'b0;
    tick();
    check("t3_gnt_b_release", 32'(gb), 32'd1);
    req_b_in = 1'b0;
    repeat (5) tick();

    // starvation of A behind the display
    do_reset();
    disp_en_in = 1'b1; req_a_in = 1'b1; addr_a_in = 17'h00042;
    repeat (20) tick();
    disp_en_in = 1'b0;
    tick();
    check("t4_gnt_a", 32'(ga), 32'd1);
    req_a_in = 1'b0;
    tick();
    check("t4_starve", 32'(st), 32'd1);
    repeat (5) tick();

    // reset while a grant is in flight
    do_reset();
    req_a_in = 1'b1; addr_a_in = 17'h0BEEF;
    tick();
    check("t5_gnt_a", 32'(ga), 32'd1);
    rst_in_n = 1'b0; req_a_in = 1'b0;
    #1;
    check("t5_rst_addr", 32'(bram_addr_out), 32'd0);
    check("t5_rst_valid", {30'd0, rd_valid_b_out, rd_valid_a_out}, 32'd0);
    tick();
    rst_in_n = 1'b1;
    repeat (6) tick();

    // request withdrawn while display owns the port
    disp_en_in = 1'b1; req_a_in = 1'b1; addr_a_in = 17'h00777;
    repeat (5) tick();
    req_a_in = 1'b0;
    repeat (3) tick();
    disp_en_in = 1'b0;
    tick();
    check("t6_starve", 32'(st), 32'd0);
    repeat (4) tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        continue;
      end
      disp_en_in   = ($urandom_range(0, 3) == 0);
      disp_addr_in = rnd_addr();
      if (req_a_in && ga)           begin req_a_in = $urandom_range(0, 1) == 1; addr_a_in = rnd_addr(); end
      else if (req_a_in)            begin if ($urandom_range(0, 15) == 0) req_a_in = 1'b0; end
      else if ($urandom_range(0, 9) < 4) begin req_a_in = 1'b1; addr_a_in = rnd_addr(); end
      if (req_b_in && gb)           begin req_b_in = $urandom_range(0, 1) == 1; addr_b_in = rnd_addr(); end
      else if (req_b_in)            begin if ($urandom_range(0, 15) == 0) req_b_in = 1'b0; end
      else if ($urandom_range(0, 9) < 4) begin req_b_in = 1'b1; addr_b_in = rnd_addr(); end
      tick();
    end
    req_a_in = 1'b0; req_b_in = 1'b0; disp_en_in = 1'b0;
    repeat (8) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
